usb_trigger_gen: RTL and testbench

//  Downstream of the USB pattern matcher: turns each single-cycle match pulse into the

---
 rtl/usb_trig_pkg.sv | 13 +
 rtl/usb_trigger_gen_sat_counter16.sv | 26 ++
 rtl/usb_trigger_gen.sv | 125 ++++++++++++
 tb/tb_usb_trigger_gen.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_trig_pkg.sv
// Shared definitions for the USB trigger generator: FSM state encoding and the
// saturation limit used by the event counters.
package usb_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } trig_state_e;

    localparam logic [15:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/usb_trigger_gen_sat_counter16.sv
// 16-bit event counter that sticks at SAT_MAX; a clear beats a simultaneous enable.
module sat_counter16
    import usb_trig_pkg::*;
(
    input  logic        fe_clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == SAT_MAX) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 16'h0;
        end else if (clr) begin
            count <= 16'h0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/usb_trigger_gen.sv
// Turns a one-cycle pattern-match pulse into a delayed, programmable-width trigger.
// Define USB_TRIG_MISSED_CNT_EN to build the counter of matches dropped while busy.
module usb_trigger_gen
    import usb_trig_pkg::*;
#(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_n,
    input  logic                    I_arm,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_width,
    input  logic                    I_match_trigger,
    output logic                    O_trigger,
    output logic                    O_busy,
    output logic [15:0]             O_trig_count,
    output logic [15:0]             O_missed_count
);

    localparam logic [pDELAY_WIDTH-1:0] D_ONE = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pWIDTH_WIDTH-1:0] W_ONE = {{(pWIDTH_WIDTH-1){1'b0}}, 1'b1};

    trig_state_e             state;
    logic                    arm_r;
    logic                    arm_rise;
    logic [pDELAY_WIDTH-1:0] dcnt;
    logic [pWIDTH_WIDTH-1:0] wcnt;
    logic [pWIDTH_WIDTH-1:0] wlen_m1;
    logic                    pulse_first;

    // A programmed width of zero still produces a one-cycle pulse.
    function automatic logic [pWIDTH_WIDTH-1:0] width_m1(input logic [pWIDTH_WIDTH-1:0] w);
        return (w == '0) ? '0 : w - W_ONE;
    endfunction

    assign arm_rise = I_arm & ~arm_r;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            arm_r       <= 1'b0;
            O_trigger   <= 1'b0;
            O_busy      <= 1'b0;
            dcnt        <= '0;
            wcnt        <= '0;
            wlen_m1     <= '0;
            pulse_first <= 1'b0;
        end else begin
            arm_r       <= I_arm;
            pulse_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_match_trigger && I_arm) begin
                        wlen_m1 <= width_m1(I_width);
                        O_busy  <= 1'b1;
                        if (I_delay == '0) begin
                            state       <= PULSE;
                            wcnt        <= width_m1(I_width);
                            O_trigger   <= 1'b1;
                            pulse_first <= 1'b1;
                        end else begin
                            state <= DELAY;
                            dcnt  <= I_delay - D_ONE;
                        end
                    end
                end
                DELAY: begin
                    if (!I_arm) begin
                        state  <= IDLE;
                        O_busy <= 1'b0;
                    end else if (dcnt == '0) begin
                        state       <= PULSE;
                        wcnt        <= wlen_m1;
                        O_trigger   <= 1'b1;
                        pulse_first <= 1'b1;
                    end else begin
                        dcnt <= dcnt - D_ONE;
                    end
                end
                PULSE: begin
                    if (!I_arm || wcnt == '0) begin
                        state     <= IDLE;
                        O_trigger <= 1'b0;
                        O_busy    <= 1'b0;
                    end else begin
                        wcnt <= wcnt - W_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    O_trigger <= 1'b0;
                    O_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Counting one cycle after PULSE entry lets an arm-edge clear and a same-cycle
    // zero-delay match both take effect, and still counts a pulse aborted early.
    sat_counter16 u_trig_cnt (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .clr     (arm_rise),
        .en      (pulse_first),
        .count   (O_trig_count)
    );

`ifdef USB_TRIG_MISSED_CNT_EN
    logic missed_en;

    assign missed_en = I_match_trigger && I_arm && (state != IDLE);

    sat_counter16 u_missed_cnt (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .clr     (arm_rise),
        .en      (missed_en),
        .count   (O_missed_count)
    );
`else
    assign O_missed_count = 16'h0;
`endif

endmodule

// File: tb/tb_usb_trigger_gen.sv
// Self-checking bench for usb_trigger_gen: directed scenarios plus a randomized
// run against a cycle-window reference model, and a saturation run of sat_counter16.
module tb_usb_trigger_gen;

    localparam int DW = 20;
    localparam int WW = 16;

`ifdef USB_TRIG_MISSED_CNT_EN
    localparam bit MISSED_EN = 1'b1;
`else
    localparam bit MISSED_EN = 1'b0;
`endif

    logic          fe_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          I_arm = 1'b0;
    logic [DW-1:0] I_delay = '0;
    logic [WW-1:0] I_width = '0;
    logic          I_match_trigger = 1'b0;
    logic          O_trigger;
    logic          O_busy;
    logic [15:0]   O_trig_count;
    logic [15:0]   O_missed_count;

    logic          sat_clr = 1'b0;
    logic          sat_en = 1'b0;
    logic [15:0]   sat_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_missed = 0;

    always #5 fe_clk = ~fe_clk;

    usb_trigger_gen #(
        .pDELAY_WIDTH (DW),
        .pWIDTH_WIDTH (WW)
    ) dut (
        .fe_clk          (fe_clk),
        .reset_n         (reset_n),
        .I_arm           (I_arm),
        .I_delay         (I_delay),
        .I_width         (I_width),
        .I_match_trigger (I_match_trigger),
        .O_trigger       (O_trigger),
        .O_busy          (O_busy),
        .O_trig_count    (O_trig_count),
        .O_missed_count  (O_missed_count)
    );

    sat_counter16 u_sat (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .clr     (sat_clr),
        .en      (sat_en),
        .count   (sat_count)
    );

    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic arm_restart();
        I_arm = 1'b0;
        I_match_trigger = 1'b0;
        step();
        I_arm = 1'b1;
        step();
        exp_cnt = 0;
        exp_missed = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (O_trigger !== 1'b0 || O_busy !== 1'b0 || O_trig_count !== 16'h0 || O_missed_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state trigger=%b busy=%b trig_count=%h missed=%h expected all zero",
                     O_trigger, O_busy, O_trig_count, O_missed_count);
        end
        #2 reset_n = 1'b1;
        step();
        checks++;
        if (O_busy !== 1'b0 || O_trigger !== 1'b0) begin
            errors++;
            $display("FAIL reset_release trigger=%b busy=%b expected 0 0", O_trigger, O_busy);
        end
    endtask

    task automatic test_single(input int d, input int w);
        int   wl;
        logic exp_t;
        logic exp_b;
        wl = (w == 0) ? 1 : w;
        I_delay = DW'(d);
        I_width = WW'(w);
        I_match_trigger = 1'b1;
        for (int k = 1; k <= d + wl + 3; k++) begin
            step();
            I_match_trigger = 1'b0;
            exp_t = (k >= d + 1) && (k <= d + wl);
            exp_b = (k >= 1) && (k <= d + wl);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_b) begin
                errors++;
                $display("FAIL single_d%0d_w%0d cyc+%0d trigger=%b busy=%b expected %b %b",
                         d, w, k, O_trigger, O_busy, exp_t, exp_b);
            end
        end
        exp_cnt++;
        checks++;
        if (O_trig_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL single_count_d%0d_w%0d got %0d expected %0d", d, w, O_trig_count, exp_cnt);
        end
    endtask

    task automatic test_basic();
        arm_restart();
        test_single(0, 1);
        test_single(5, 3);
        test_single(2, 0);
    endtask

    task automatic test_back_to_back();
        logic exp_t;
        logic exp_b;
        arm_restart();
        I_delay = DW'(4);
        I_width = WW'(2);
        I_match_trigger = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            I_match_trigger = (k == 3);
            exp_t = (k >= 5) && (k <= 6);
            exp_b = (k >= 1) && (k <= 6);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_b) begin
                errors++;
                $display("FAIL back_to_back cyc+%0d trigger=%b busy=%b expected %b %b",
                         k, O_trigger, O_busy, exp_t, exp_b);
            end
        end
        exp_cnt++;
        exp_missed++;
        checks++;
        if (O_trig_count !== 16'(exp_cnt) || O_missed_count !== (MISSED_EN ? 16'(exp_missed) : 16'h0)) begin
            errors++;
            $display("FAIL back_to_back_counts trig=%0d missed=%0d expected trig=%0d missed=%0d",
                     O_trig_count, O_missed_count, exp_cnt, MISSED_EN ? exp_missed : 0);
        end
    endtask

    task automatic test_width0_config();
        logic exp_t;
        logic exp_b;
        I_delay = DW'(3);
        I_width = WW'(0);
        I_match_trigger = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            I_match_trigger = 1'b0;
            if (k == 2) begin
                I_delay = DW'(50);
                I_width = WW'(9);
            end
            exp_t = (k == 4);
            exp_b = (k >= 1) && (k <= 4);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_b) begin
                errors++;
                $display("FAIL width0_config cyc+%0d trigger=%b busy=%b expected %b %b",
                         k, O_trigger, O_busy, exp_t, exp_b);
            end
        end
    endtask

    task automatic test_arm_abort();
        logic exp_t;
        logic exp_b;
        arm_restart();
        I_delay = DW'(100);
        I_width = WW'(4);
        I_match_trigger = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            I_match_trigger = 1'b0;
            exp_b = (k <= 50);
            checks++;
            if (O_trigger !== 1'b0 || O_busy !== exp_b) begin
                errors++;
                $display("FAIL abort_delay cyc+%0d trigger=%b busy=%b expected 0 %b",
                         k, O_trigger, O_busy, exp_b);
            end
            if (k == 50) I_arm = 1'b0;
        end
        checks++;
        if (O_trig_count !== 16'h0) begin
            errors++;
            $display("FAIL abort_delay_count got %0d expected 0", O_trig_count);
        end
        arm_restart();
        I_delay = DW'(2);
        I_width = WW'(10);
        I_match_trigger = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            I_match_trigger = 1'b0;
            exp_t = (k >= 3) && (k <= 5);
            exp_b = (k >= 1) && (k <= 5);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_b) begin
                errors++;
                $display("FAIL abort_pulse cyc+%0d trigger=%b busy=%b expected %b %b",
                         k, O_trigger, O_busy, exp_t, exp_b);
            end
            if (k == 5) I_arm = 1'b0;
        end
        exp_cnt = 1;
        checks++;
        if (O_trig_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL abort_pulse_count got %0d expected %0d", O_trig_count, exp_cnt);
        end
    endtask

    task automatic test_arm_rise_match();
        logic exp_t;
        I_delay = DW'(0);
        I_width = WW'(1);
        I_arm = 1'b1;
        I_match_trigger = 1'b1;
        exp_cnt = 0;
        exp_missed = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            I_match_trigger = 1'b0;
            exp_t = (k == 1);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_t) begin
                errors++;
                $display("FAIL arm_rise_match cyc+%0d trigger=%b busy=%b expected %b %b",
                         k, O_trigger, O_busy, exp_t, exp_t);
            end
        end
        exp_cnt++;
        checks++;
        if (O_trig_count !== 16'(exp_cnt) || O_missed_count !== 16'h0) begin
            errors++;
            $display("FAIL arm_rise_count trig=%0d missed=%0d expected trig=%0d missed=0",
                     O_trig_count, O_missed_count, exp_cnt);
        end
    endtask

    task automatic test_random();
        int   win_acc;
        int   win_start;
        int   win_end;
        int   d;
        int   w;
        int   n_acc;
        int   n_miss;
        logic m;
        logic exp_t;
        logic exp_b;
        arm_restart();
        win_acc = -100;
        win_start = -100;
        win_end = -100;
        n_acc = 0;
        n_miss = 0;
        for (int c = 0; c < 3020; c++) begin
            exp_t = (c >= win_start) && (c <= win_end);
            exp_b = (c >= win_acc + 1) && (c <= win_end);
            checks++;
            if (O_trigger !== exp_t || O_busy !== exp_b) begin
                errors++;
                $display("FAIL random cyc%0d trigger=%b busy=%b expected %b %b",
                         c, O_trigger, O_busy, exp_t, exp_b);
            end
            m = (c < 3000) && ($urandom_range(0, 3) == 0);
            d = int'($urandom_range(0, 6));
            w = int'($urandom_range(0, 4));
            I_match_trigger = m;
            I_delay = DW'(d);
            I_width = WW'(w);
            if (m) begin
                if (c > win_end) begin
                    win_acc = c;
                    win_start = c + 1 + d;
                    win_end = c + d + ((w == 0) ? 1 : w);
                    n_acc++;
                end else begin
                    n_miss++;
                end
            end
            step();
        end
        I_match_trigger = 1'b0;
        checks++;
        if (O_trig_count !== 16'(n_acc) || O_missed_count !== (MISSED_EN ? 16'(n_miss) : 16'h0)) begin
            errors++;
            $display("FAIL random_counts trig=%0d missed=%0d expected trig=%0d missed=%0d",
                     O_trig_count, O_missed_count, n_acc, MISSED_EN ? n_miss : 0);
        end
    endtask

    task automatic test_async_reset();
        arm_restart();
        I_delay = DW'(0);
        I_width = WW'(8);
        I_match_trigger = 1'b1;
        repeat (3) begin
            step();
            I_match_trigger = 1'b0;
        end
        checks++;
        if (O_trigger !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_pre trigger=%b expected 1", O_trigger);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (O_trigger !== 1'b0 || O_busy !== 1'b0 || O_trig_count !== 16'h0) begin
            errors++;
            $display("FAIL async_reset trigger=%b busy=%b count=%0d expected 0 0 0",
                     O_trigger, O_busy, O_trig_count);
        end
        #1 reset_n = 1'b1;
        step();
        step();
        checks++;
        if (O_trigger !== 1'b0 || O_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_after trigger=%b busy=%b expected 0 0", O_trigger, O_busy);
        end
    endtask

    task automatic test_saturation();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        sat_en = 1'b1;
        repeat (1000) step();
        checks++;
        if (sat_count !== 16'd1000) begin
            errors++;
            $display("FAIL sat_mid got %0d expected 1000", sat_count);
        end
        repeat (64535) step();
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach got %h expected ffff", sat_count);
        end
        repeat (5) step();
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h expected ffff", sat_count);
        end
        sat_clr = 1'b1;
        step();
        checks++;
        if (sat_count !== 16'h0) begin
            errors++;
            $display("FAIL sat_clear_priority got %h expected 0", sat_count);
        end
        sat_clr = 1'b0;
        step();
        sat_en = 1'b0;
        checks++;
        if (sat_count !== 16'd1) begin
            errors++;
            $display("FAIL sat_restart got %0d expected 1", sat_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_width0_config();
        test_arm_abort();
        test_arm_rise_match();
        test_random();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
